stack_port_ctrl: RTL and testbench

//  Sequential push/pop engine that owns the stack pointer and drives the data-memory port.

---
 rtl/stack_port_ctrl_if.sv | 42 ++++
 rtl/stack_port_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_stack_port_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_port_ctrl_if.sv
// -----------------------------------------------------------------------------
// stack_port_ctrl_if
//   Data-memory port between the stack push/pop engine and the shared memory
//   arbiter. This is a request/acknowledge handshake: the engine raises mem_req
//   together with a stable command. The arbiter then answers with a one-cycle
//   mem_ack.
//
//   mem_req    engine -> arbiter  request, held high until mem_ack
//   mem_we     engine -> arbiter  1 = write, 0 = read (valid while mem_req)
//   mem_addr   engine -> arbiter  word address (stable while mem_req)
//   mem_wdata  engine -> arbiter  write data (stable while mem_req)
//   mem_ack    arbiter -> engine  one-cycle completion pulse
//   mem_rdata  arbiter -> engine  read data, valid in the mem_ack cycle
// -----------------------------------------------------------------------------
interface stack_port_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  // The stack engine initiates transfers.
  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  // The memory arbiter completes them.
  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface : stack_port_ctrl_if

// File: rtl/stack_port_ctrl.sv
// -----------------------------------------------------------------------------
// stack_port_ctrl
//   Push/pop engine. It owns the stack pointer and drives the data-memory port.
//   The stack grows downward:
//     - push writes to SP-1 (pre-decrement)
//     - pop reads from SP (post-increment)
//   Stack addresses live in a 14-bit compressed space in which SP bits 11:10
//   are always zero. All pointer arithmetic is therefore done on
//   e = {SP[15:12], SP[9:0]}, modulo 2^14, and the result is re-expanded.
//
// Parameters
//   SP_INIT    empty-stack SP (one above the first slot); bits 11:10 = 0
//   SP_LIMIT   lowest usable slot; a push at SP == SP_LIMIT overflows
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   push_req       push request, sampled only while ready
//   pop_req        pop request, sampled only while ready
//   push_data      word to push, captured when the push is accepted
//   ready          idle and able to accept a request
//   pop_valid      one-cycle pulse; pop_data is valid in the same cycle
//   pop_data       last popped word, held until the next pop completes
//   sp             current stack pointer
//   ovf / unf      one-cycle pulses: push rejected (full) / pop rejected (empty)
//   mem_bus        memory request/acknowledge port (master side)
// -----------------------------------------------------------------------------
module stack_port_ctrl #(
  parameter logic [15:0] SP_INIT  = 16'hF3FF,
  parameter logic [15:0] SP_LIMIT = 16'hE000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_req,
  input  logic                      pop_req,
  input  logic [15:0]               push_data,
  output logic                      ready,
  output logic                      pop_valid,
  output logic [15:0]               pop_data,
  output logic [15:0]               sp,
  output logic                      ovf,
  output logic                      unf,
  stack_port_ctrl_if.master         mem_bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,   // waiting for a push/pop request
    S_WR   = 2'd1,   // push in flight: memory write outstanding
    S_RD   = 2'd2    // pop in flight: memory read outstanding
  } state_e;

  // ---------------------------------------------------------------------------
  // Compressed-address helpers
  // ---------------------------------------------------------------------------
  function automatic logic [13:0] compress(input logic [15:0] addr);
    return {addr[15:12], addr[9:0]};
  endfunction

  function automatic logic [15:0] expand(input logic [13:0] e);
    return {e[13:10], 2'b00, e[9:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e      state_q,     state_d;
  logic [15:0] sp_q,        sp_d;
  logic [15:0] addr_q,      addr_d;
  logic [15:0] wdata_q,     wdata_d;
  logic        we_q,        we_d;
  logic [15:0] pop_data_q,  pop_data_d;
  logic        pop_valid_q, pop_valid_d;
  logic        ovf_q,       ovf_d;
  logic        unf_q,       unf_d;

  // Neighbouring pointers. Both wrap modulo 2^14 in the compressed space:
  //   0000 - 1 -> F3FF
  //   F3FF + 1 -> 0000
  logic [13:0] sp_e;
  logic [13:0] sp_e_dec;
  logic [13:0] sp_e_inc;
  logic [15:0] sp_dec;
  logic [15:0] sp_inc;
  logic        sp_full;    // next push would go below SP_LIMIT
  logic        sp_empty;   // nothing to pop

  assign sp_e     = compress(sp_q);
  assign sp_e_dec = sp_e - 14'd1;
  assign sp_e_inc = sp_e + 14'd1;
  assign sp_dec   = expand(sp_e_dec);
  assign sp_inc   = expand(sp_e_inc);
  assign sp_full  = (sp_q == SP_LIMIT);
  assign sp_empty = (sp_q == SP_INIT);

  // ---------------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential blocks use non-blocking assignments. Every flop then
  // samples pre-edge values, independent of the order of the always blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case statement.
  // A path that leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        // A push takes priority. A pop arriving in the same cycle is dropped.
        if (push_req) begin
          if (!sp_full) begin
            state_d = S_WR;
          end
        end else if (pop_req && !sp_empty) begin
          state_d = S_RD;
        end
      end
      S_WR, S_RD: begin
        // No timeout: the engine waits for mem_ack as long as it takes.
        if (mem_bus.mem_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-value logic
  // ---------------------------------------------------------------------------
  always_comb begin
    sp_d        = sp_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    ovf_d       = 1'b0;
    unf_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (push_req) begin
          if (sp_full) begin
            ovf_d = 1'b1;
          end else begin
            // Pre-decrement: the write goes to SP-1. SP itself moves only on ack.
            addr_d  = sp_dec;
            wdata_d = push_data;
            we_d    = 1'b1;
          end
        end else if (pop_req) begin
          if (sp_empty) begin
            unf_d = 1'b1;
          end else begin
            addr_d = sp_q;
            we_d   = 1'b0;
          end
        end
      end
      S_WR: begin
        if (mem_bus.mem_ack) begin
          // The address just written is the new top of stack.
          sp_d = addr_q;
        end
      end
      S_RD: begin
        // mem_rdata is looked at only here, in the ack cycle of a read.
        if (mem_bus.mem_ack) begin
          pop_data_d  = mem_bus.mem_rdata;
          pop_valid_d = 1'b1;
          sp_d        = sp_inc;
        end
      end
      default: ;
    endcase
  end

  // NOTE: the datapath registers are reset explicitly even though they are only
  // data. The bus and pop_data outputs are then defined (zero) straight out of
  // reset, and not just after the first transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q        <= SP_INIT;
      addr_q      <= 16'h0000;
      wdata_q     <= 16'h0000;
      we_q        <= 1'b0;
      pop_data_q  <= 16'h0000;
      pop_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: outputs
  // ---------------------------------------------------------------------------
  // mem_req is decoded from the state register. Because that register resets
  // asynchronously, the request drops as soon as rst_n falls.
  always_comb begin
    ready             = (state_q == S_IDLE);
    mem_bus.mem_req   = (state_q != S_IDLE);
    mem_bus.mem_we    = we_q;
    mem_bus.mem_addr  = addr_q;
    mem_bus.mem_wdata = wdata_q;
    sp                = sp_q;
    pop_data          = pop_data_q;
    pop_valid         = pop_valid_q;
    ovf               = ovf_q;
    unf               = unf_q;
  end

endmodule : stack_port_ctrl

// File: tb/tb_stack_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stack_port_ctrl
//   Three engines run side by side on the same push/pop stimulus:
//     dut0: default parameters
//     dut1: SP_INIT = 16'h1000 (crosses the hole at address bits 11:10)
//     dut2: SP_LIMIT = 16'hF3FD (two-slot stack, overflows quickly)
//   Each engine has its own arbiter with a programmable ack delay and a
//   backing memory. A stack model (an array plus a depth count) predicts every
//   output on every cycle. Literal checks at key points pin the model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stack_port_ctrl;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        push_req  = 1'b0;
  logic        pop_req   = 1'b0;
  logic [15:0] push_data = 16'h0000;

  logic [N-1:0]       rdy_w, pv_w, ovf_w, unf_w, req_w, we_w;
  logic [N-1:0][15:0] sp_w, pd_w, addr_w, wdata_w;
  logic [N-1:0]       ack_r;
  logic [N-1:0][15:0] rdata_r;

  int ack_delay = 3;   // ack arrives in the Nth cycle of mem_req; 0 = never
  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // ---------------------------------------------------------------------------
  // DUT instances
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < N; g++) begin : g_dut
    stack_port_ctrl_if bus ();
    assign bus.mem_ack   = ack_r[g];
    assign bus.mem_rdata = rdata_r[g];
    assign req_w[g]      = bus.mem_req;
    assign we_w[g]       = bus.mem_we;
    assign addr_w[g]     = bus.mem_addr;
    assign wdata_w[g]    = bus.mem_wdata;

    stack_port_ctrl #(
      .SP_INIT (g == 1 ? 16'h1000 : 16'hF3FF),
      .SP_LIMIT(g == 2 ? 16'hF3FD : 16'hE000)
    ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_req (push_req),
      .pop_req  (pop_req),
      .push_data(push_data),
      .ready    (rdy_w[g]),
      .pop_valid(pv_w[g]),
      .pop_data (pd_w[g]),
      .sp       (sp_w[g]),
      .ovf      (ovf_w[g]),
      .unf      (unf_w[g]),
      .mem_bus  (bus)
    );
  end

  // ---------------------------------------------------------------------------
  // Arbiter and backing memory
  // ---------------------------------------------------------------------------
  int          arb_cnt [N];
  logic [15:0] bmem    [N][65536];

  always_comb begin
    ack_r   = '0;
    rdata_r = '0;
    for (int i = 0; i < N; i++) begin
      ack_r[i]   = req_w[i] && (ack_delay != 0) && (arb_cnt[i] + 1 == ack_delay);
      rdata_r[i] = bmem[i][addr_w[i]];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        arb_cnt[i] <= 0;
      end else begin
        arb_cnt[i] <= (req_w[i] && !ack_r[i]) ? arb_cnt[i] + 1 : 0;
        if (ack_r[i] && we_w[i]) bmem[i][addr_w[i]] <= wdata_w[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Model: a real stack (array + depth). SP is derived from the depth.
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] init_of(input int i);
    return (i == 1) ? 16'h1000 : 16'hF3FF;
  endfunction

  function automatic logic [15:0] limit_of(input int i);
    return (i == 2) ? 16'hF3FD : 16'hE000;
  endfunction

  // Linear slot index of an address in the 14-bit stack space.
  function automatic int slot(input logic [15:0] a);
    return int'(a[15:12]) * 1024 + int'(a[9:0]);
  endfunction

  // Address of the stack word that sits k entries below the empty pointer.
  function automatic logic [15:0] addr_of(input int i, input int k);
    int e;
    e = (slot(init_of(i)) - k + 16384) % 16384;
    return {4'(e / 1024), 2'b00, 10'(e % 1024)};
  endfunction

  function automatic int cap_of(input int i);
    return (slot(init_of(i)) - slot(limit_of(i)) + 16384) % 16384;
  endfunction

  typedef enum int {OP_NONE, OP_PUSH, OP_POP} op_e;

  op_e         m_op    [N];
  int          m_depth [N];
  logic [15:0] m_stk   [N][64];
  logic [15:0] m_addr  [N];
  logic [15:0] m_wdata [N];
  logic [15:0] m_pd    [N];
  logic        m_pv    [N];
  logic        m_ovf   [N];
  logic        m_unf   [N];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        m_op[i]    <= OP_NONE;
        m_depth[i] <= 0;
        m_pd[i]    <= 16'h0000;
        m_pv[i]    <= 1'b0;
        m_ovf[i]   <= 1'b0;
        m_unf[i]   <= 1'b0;
      end else begin
        m_pv[i]  <= 1'b0;
        m_ovf[i] <= 1'b0;
        m_unf[i] <= 1'b0;
        case (m_op[i])
          OP_NONE: begin
            if (push_req) begin
              if (m_depth[i] == cap_of(i)) begin
                m_ovf[i] <= 1'b1;
              end else begin
                m_op[i]    <= OP_PUSH;
                m_addr[i]  <= addr_of(i, m_depth[i] + 1);
                m_wdata[i] <= push_data;
              end
            end else if (pop_req) begin
              if (m_depth[i] == 0) begin
                m_unf[i] <= 1'b1;
              end else begin
                m_op[i]   <= OP_POP;
                m_addr[i] <= addr_of(i, m_depth[i]);
              end
            end
          end
          OP_PUSH: if (ack_r[i]) begin
            m_stk[i][m_depth[i]] <= m_wdata[i];
            m_depth[i]           <= m_depth[i] + 1;
            m_op[i]              <= OP_NONE;
          end
          OP_POP: if (ack_r[i]) begin
            m_pd[i]    <= m_stk[i][m_depth[i] - 1];
            m_pv[i]    <= 1'b1;
            m_depth[i] <= m_depth[i] - 1;
            m_op[i]    <= OP_NONE;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("dut%0d.ready", i),     16'(rdy_w[i]), 16'(m_op[i] == OP_NONE));
        check($sformatf("dut%0d.mem_req", i),   16'(req_w[i]), 16'(m_op[i] != OP_NONE));
        check($sformatf("dut%0d.sp", i),        sp_w[i],       addr_of(i, m_depth[i]));
        check($sformatf("dut%0d.pop_valid", i), 16'(pv_w[i]),  16'(m_pv[i]));
        check($sformatf("dut%0d.pop_data", i),  pd_w[i],       m_pd[i]);
        check($sformatf("dut%0d.ovf", i),       16'(ovf_w[i]), 16'(m_ovf[i]));
        check($sformatf("dut%0d.unf", i),       16'(unf_w[i]), 16'(m_unf[i]));
        if (m_op[i] != OP_NONE) begin
          check($sformatf("dut%0d.mem_we", i),    16'(we_w[i]), 16'(m_op[i] == OP_PUSH));
          check($sformatf("dut%0d.mem_addr", i),  addr_w[i],    m_addr[i]);
          if (m_op[i] == OP_PUSH)
            check($sformatf("dut%0d.mem_wdata", i), wdata_w[i], m_wdata[i]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // Present a request for exactly one sampling edge.
  task automatic do_req(input logic psh, input logic pp, input logic [15:0] d);
    @(posedge clk); #1;
    push_req  = psh;
    pop_req   = pp;
    push_data = d;
    @(posedge clk); #1;
    push_req  = 1'b0;
    pop_req   = 1'b0;
    push_data = 16'hFFFF;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rdy_w != '1 && n < budget);
    check("wait_idle", 16'(rdy_w), 16'(3'b111));
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    repeat (2) @(negedge clk);
    check("rst.sp0",    sp_w[0],      16'hF3FF);
    check("rst.sp1",    sp_w[1],      16'h1000);
    check("rst.ready",  16'(rdy_w),   16'(3'b111));
    check("rst.req",    16'(req_w),   16'h0000);
    check("rst.we",     16'(we_w),    16'h0000);
    check("rst.addr0",  addr_w[0],    16'h0000);
    check("rst.wdata0", wdata_w[0],   16'h0000);
    check("rst.pdata0", pd_w[0],      16'h0000);
    check("rst.pulses", 16'({pv_w, ovf_w, unf_w}), 16'h0000);
    cmp_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Push BEEF, ack in the third request cycle.
    ack_delay = 3;
    do_req(1'b1, 1'b0, 16'hBEEF);
    @(negedge clk);
    check("t1.addr0",  addr_w[0],      16'hF3FE);
    check("t1.wdata0", wdata_w[0],     16'hBEEF);
    check("t1.we0",    16'(we_w[0]),   16'h0001);
    check("t1.addr1",  addr_w[1],      16'h03FF);
    check("t1.ready0", 16'(rdy_w[0]),  16'h0000);
    wait_idle(20);
    check("t1.sp0", sp_w[0], 16'hF3FE);
    check("t1.sp1", sp_w[1], 16'h03FF);

    // Pop it back.
    do_req(1'b0, 1'b1, 16'h0000);
    @(negedge clk);
    check("t2.addr0", addr_w[0],    16'hF3FE);
    check("t2.we0",   16'(we_w[0]), 16'h0000);
    check("t2.addr1", addr_w[1],    16'h03FF);
    wait_idle(20);
    check("t2.pv0",    16'(pv_w[0]), 16'h0001);
    check("t2.pdata0", pd_w[0],      16'hBEEF);
    check("t2.sp0",    sp_w[0],      16'hF3FF);
    check("t2.sp1",    sp_w[1],      16'h1000);

    // Pop on an empty stack.
    do_req(1'b0, 1'b1, 16'h0000);
    @(negedge clk);
    check("t4.unf",  16'(unf_w), 16'(3'b111));
    check("t4.req",  16'(req_w), 16'h0000);
    @(negedge clk);
    check("t4.unf_clr", 16'(unf_w), 16'h0000);
    check("t4.pdata0",  pd_w[0],    16'hBEEF);

    // Three pushes with different ack delays; dut2 overflows on the third.
    ack_delay = 1;
    do_req(1'b1, 1'b0, 16'h1111);
    wait_idle(20);
    ack_delay = 2;
    do_req(1'b1, 1'b0, 16'h2222);
    wait_idle(20);
    ack_delay = 5;
    do_req(1'b1, 1'b0, 16'h3333);
    @(negedge clk);
    check("t4.ovf2",   16'(ovf_w[2]), 16'h0001);
    check("t4.sp2",    sp_w[2],       16'hF3FD);
    check("t4.ready2", 16'(rdy_w[2]), 16'h0001);
    check("t4.req2",   16'(req_w[2]), 16'h0000);
    wait_idle(20);
    check("t4.ovf_clr", 16'(ovf_w), 16'h0000);
    check("t4.sp0",     sp_w[0],    16'hF3FC);

    // Drain two entries, then issue a push and a pop together.
    ack_delay = 2;
    do_req(1'b0, 1'b1, 16'h0000);
    wait_idle(20);
    check("t5.pd0a", pd_w[0], 16'h3333);
    check("t5.pd2a", pd_w[2], 16'h2222);
    do_req(1'b0, 1'b1, 16'h0000);
    wait_idle(20);
    check("t5.pd0b", pd_w[0], 16'h2222);
    check("t5.pd2b", pd_w[2], 16'h1111);
    check("t5.sp0",  sp_w[0], 16'hF3FE);
    check("t5.sp2",  sp_w[2], 16'hF3FF);
    do_req(1'b1, 1'b1, 16'h4444);
    @(negedge clk);
    check("t5.addr0", addr_w[0],     16'hF3FD);
    check("t5.we0",   16'(we_w[0]),  16'h0001);
    check("t5.addr2", addr_w[2],     16'hF3FE);
    check("t5.unf2",  16'(unf_w[2]), 16'h0000);
    wait_idle(20);
    check("t5.pv",  16'(pv_w), 16'h0000);
    check("t5.sp0", sp_w[0],   16'hF3FD);

    // Reset while a read waits for an ack that never comes.
    ack_delay = 0;
    do_req(1'b0, 1'b1, 16'h0000);
    repeat (2) @(negedge clk);
    check("t6.req_wait", 16'(req_w), 16'(3'b111));
    #2 rst_n = 1'b0;
    #1;
    check("t6.req_drop", 16'(req_w), 16'h0000);
    check("t6.sp0",      sp_w[0],    16'hF3FF);
    check("t6.sp1",      sp_w[1],    16'h1000);
    check("t6.ready",    16'(rdy_w), 16'(3'b111));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6.no_pv", 16'(pv_w), 16'h0000);
    end

    // Engine works normally after the abandoned transfer.
    ack_delay = 1;
    do_req(1'b1, 1'b0, 16'h5555);
    wait_idle(20);
    check("t6.sp0_after", sp_w[0], 16'hF3FE);
    check("t6.sp1_after", sp_w[1], 16'h03FF);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule : tb_stack_port_ctrl
